// File: rtl/two_digit_bcd_sync_down_cntr_pkg.sv
// Shared BCD constants and the digit clamp used on parallel load.
package two_digit_bcd_sync_down_cntr_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX  = 4'd9;
  localparam logic [DIGIT_W-1:0] BCD_ZERO = 4'd0;

  // Non-BCD digits (A..F) saturate to 9 so the counter never holds an illegal digit.
  function automatic logic [DIGIT_W-1:0] bcd_clamp(input logic [DIGIT_W-1:0] d);
    logic [DIGIT_W-1:0] r;
    if (d > BCD_MAX) begin
      r = BCD_MAX;
    end else begin
      r = d;
    end
    return r;
  endfunction

endpackage

// File: rtl/two_digit_bcd_sync_down_cntr_digit.sv
// One BCD digit down counter with clamped load and 0 -> 9 wrap; borrow feeds the next digit.
module bcd_digit_sync_down_cntr
  import two_digit_bcd_sync_down_cntr_pkg::*;
(
  input  logic               rstn,
  input  logic               clk,
  input  logic               clrn,
  input  logic               cnt_en,
  input  logic               load,
  input  logic [DIGIT_W-1:0] I,
  output logic [DIGIT_W-1:0] count,
  output logic               borrow
);

  logic [DIGIT_W-1:0] count_q;
  logic [DIGIT_W-1:0] count_d;

  // next-state: clear > load > decrement > hold
  always_comb begin
    count_d = count_q;
    if (!clrn) begin
      count_d = BCD_ZERO;
    end else if (load) begin
      count_d = bcd_clamp(I);
    end else if (cnt_en) begin
      if (count_q == BCD_ZERO) begin
        count_d = BCD_MAX;
      end else begin
        count_d = count_q - 4'd1;
      end
    end else begin
      count_d = count_q;
    end
  end

  // digit state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= BCD_ZERO;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign borrow = cnt_en && (count_q == BCD_ZERO);

endmodule

// File: rtl/two_digit_bcd_sync_down_cntr.sv
// Two-digit BCD down counter: units digit cascades its borrow into the tens digit enable.
module two_digit_bcd_sync_down_cntr
  import two_digit_bcd_sync_down_cntr_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       clrn,
  input  logic       cnt_en,
  input  logic       load,
  input  logic [7:0] I,
  output logic [7:0] count,
  output logic       borrow,
  output logic       zero,
  output logic       done
);

  logic [DIGIT_W-1:0] units_s;
  logic [DIGIT_W-1:0] tens_s;
  logic               units_borrow_s;
  logic               tens_borrow_s;
  logic               done_q;
  logic               done_d;

  bcd_digit_sync_down_cntr u_units (
    .rstn   (rstn),
    .clk    (clk),
    .clrn   (clrn),
    .cnt_en (cnt_en),
    .load   (load),
    .I      (I[3:0]),
    .count  (units_s),
    .borrow (units_borrow_s)
  );

  bcd_digit_sync_down_cntr u_tens (
    .rstn   (rstn),
    .clk    (clk),
    .clrn   (clrn),
    .cnt_en (units_borrow_s),
    .load   (load),
    .I      (I[7:4]),
    .count  (tens_s),
    .borrow (tens_borrow_s)
  );

  // done fires only for an enable-driven 01 -> 00 step, never for clear or load
  always_comb begin
    done_d = 1'b0;
    if (!clrn) begin
      done_d = 1'b0;
    end else if (load) begin
      done_d = 1'b0;
    end else if (cnt_en && (tens_s == BCD_ZERO) && (units_s == 4'd1)) begin
      done_d = 1'b1;
    end else begin
      done_d = 1'b0;
    end
  end

  // done pulse register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
    end
  end

  assign count  = {tens_s, units_s};
  assign borrow = tens_borrow_s;
  assign zero   = (tens_s == BCD_ZERO) && (units_s == BCD_ZERO);
  assign done   = done_q;

endmodule

// File: tb/tb_two_digit_bcd_sync_down_cntr.sv
// Directed and model-checked bench for the two-digit BCD down counter.
module tb_two_digit_bcd_sync_down_cntr;

  logic       clk;
  logic       rstn;
  logic       clrn;
  logic       cnt_en;
  logic       load;
  logic [7:0] I;
  logic [7:0] count;
  logic       borrow;
  logic       zero;
  logic       done;

  int n_cmp;
  int n_err;

  two_digit_bcd_sync_down_cntr dut (
    .clk    (clk),
    .rstn   (rstn),
    .clrn   (clrn),
    .cnt_en (cnt_en),
    .load   (load),
    .I      (I),
    .count  (count),
    .borrow (borrow),
    .zero   (zero),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ref_dec(input logic [7:0] v);
    int n;
    n = int'(v[7:4]) * 10 + int'(v[3:0]);
    n = (n == 0) ? 99 : n - 1;
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  function automatic logic [7:0] ref_clamp(input logic [7:0] v);
    logic [3:0] t;
    logic [3:0] u;
    t = (v[7:4] > 4'd9) ? 4'd9 : v[7:4];
    u = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
    return {t, u};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; clrn = 1'b1; cnt_en = 1'b0; load = 1'b0; I = 8'h00;
    #3;
    n_cmp++; if (count !== 8'h00) begin n_err++; $display("FAIL reset_count actual=%h required=%h", count, 8'h00); end
    n_cmp++; if (zero !== 1'b1) begin n_err++; $display("FAIL reset_zero actual=%b required=1", zero); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done actual=%b required=0", done); end
    tick(); tick();
    rstn = 1'b1;
    load = 1'b1; I = 8'h05;
    tick();
    load = 1'b0; cnt_en = 1'b1;
    tick(); tick();
    n_cmp++; if (count !== 8'h03) begin n_err++; $display("FAIL premid_count actual=%h required=%h", count, 8'h03); end
    #2 rstn = 1'b0;
    #1;
    n_cmp++; if (count !== 8'h00) begin n_err++; $display("FAIL midreset_count actual=%h required=%h", count, 8'h00); end
    n_cmp++; if (zero !== 1'b1) begin n_err++; $display("FAIL midreset_zero actual=%b required=1", zero); end
    n_cmp++; if (borrow !== 1'b1) begin n_err++; $display("FAIL midreset_borrow actual=%b required=1", borrow); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL midreset_done actual=%b required=0", done); end
    cnt_en = 1'b0;
    tick();
    rstn = 1'b1;
    #1;
    n_cmp++; if (borrow !== 1'b0) begin n_err++; $display("FAIL idle_borrow actual=%b required=0", borrow); end
    tick(); tick();
    n_cmp++; if (count !== 8'h00) begin n_err++; $display("FAIL idle_hold actual=%h required=%h", count, 8'h00); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL idle_done actual=%b required=0", done); end
    cnt_en = 1'b1;
    tick();
    n_cmp++; if (count !== 8'h99) begin n_err++; $display("FAIL resume_count actual=%h required=%h", count, 8'h99); end
    cnt_en = 1'b0;
  endtask

  task automatic test_count_sequence();
    logic [7:0] seq [13];
    logic [7:0] prev;
    int done_seen;
    seq = '{8'h11, 8'h10, 8'h09, 8'h08, 8'h07, 8'h06, 8'h05,
            8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'h99};
    done_seen = 0;
    load = 1'b1; I = 8'h12; cnt_en = 1'b0;
    tick();
    load = 1'b0;
    n_cmp++; if (count !== 8'h12) begin n_err++; $display("FAIL seq_load actual=%h required=%h", count, 8'h12); end
    prev = 8'h12;
    cnt_en = 1'b1;
    for (int k = 0; k < 13; k++) begin
      #1;
      n_cmp++; if (borrow !== (prev == 8'h00)) begin n_err++; $display("FAIL seq_borrow step=%0d actual=%b required=%b", k, borrow, (prev == 8'h00)); end
      tick();
      n_cmp++; if (count !== seq[k]) begin n_err++; $display("FAIL seq_count step=%0d actual=%h required=%h", k, count, seq[k]); end
      n_cmp++; if (done !== (prev == 8'h01)) begin n_err++; $display("FAIL seq_done step=%0d actual=%b required=%b", k, done, (prev == 8'h01)); end
      if (done === 1'b1) done_seen++;
      prev = seq[k];
    end
    cnt_en = 1'b0;
    tick();
    n_cmp++; if (done_seen != 1) begin n_err++; $display("FAIL seq_done_count actual=%0d required=1", done_seen); end
    n_cmp++; if (count !== 8'h99) begin n_err++; $display("FAIL seq_hold actual=%h required=%h", count, 8'h99); end
  endtask

  task automatic test_load_clamp();
    logic [7:0] vin [3];
    logic [7:0] vexp [3];
    vin  = '{8'hFC, 8'h5B, 8'hA3};
    vexp = '{8'h99, 8'h59, 8'h93};
    for (int k = 0; k < 3; k++) begin
      load = 1'b1; I = vin[k];
      tick();
      n_cmp++; if (count !== vexp[k]) begin n_err++; $display("FAIL clamp_load in=%h actual=%h required=%h", vin[k], count, vexp[k]); end
    end
    load = 1'b0;
  endtask

  task automatic test_simultaneous();
    load = 1'b1; I = 8'h45;
    tick();
    clrn = 1'b0; load = 1'b1; I = 8'h77;
    tick();
    n_cmp++; if (count !== 8'h00) begin n_err++; $display("FAIL clr_over_load actual=%h required=%h", count, 8'h00); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL clr_done actual=%b required=0", done); end
    clrn = 1'b1; load = 1'b1; cnt_en = 1'b1; I = 8'h30;
    tick();
    n_cmp++; if (count !== 8'h30) begin n_err++; $display("FAIL load_over_en actual=%h required=%h", count, 8'h30); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL load_en_done actual=%b required=0", done); end
    I = 8'h01; cnt_en = 1'b0;
    tick();
    I = 8'h00; cnt_en = 1'b1;
    tick();
    n_cmp++; if (count !== 8'h00) begin n_err++; $display("FAIL load_zero actual=%h required=%h", count, 8'h00); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL load_zero_done actual=%b required=0", done); end
    load = 1'b0; cnt_en = 1'b0;
  endtask

  task automatic test_tens_borrow();
    load = 1'b1; I = 8'h70;
    tick();
    load = 1'b0; cnt_en = 1'b1;
    tick();
    cnt_en = 1'b0;
    n_cmp++; if (count !== 8'h69) begin n_err++; $display("FAIL tens_borrow actual=%h required=%h", count, 8'h69); end
    clrn = 1'b0;
    tick();
    clrn = 1'b1; cnt_en = 1'b1;
    #1;
    n_cmp++; if (borrow !== 1'b1) begin n_err++; $display("FAIL wrap_borrow actual=%b required=1", borrow); end
    tick();
    cnt_en = 1'b0;
    n_cmp++; if (count !== 8'h99) begin n_err++; $display("FAIL wrap_count actual=%h required=%h", count, 8'h99); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL wrap_done actual=%b required=0", done); end
  endtask

  task automatic test_random();
    logic [7:0] mdl;
    logic       mdone;
    logic       nd;
    mdl = count;
    for (int k = 0; k < 300; k++) begin
      clrn   = ($urandom_range(0, 15) != 0);
      load   = ($urandom_range(0, 7) == 0);
      cnt_en = ($urandom_range(0, 3) != 0);
      I      = 8'($urandom_range(0, 255));
      #1;
      n_cmp++; if (borrow !== (cnt_en && mdl == 8'h00)) begin n_err++; $display("FAIL rnd_borrow cyc=%0d actual=%b required=%b", k, borrow, (cnt_en && mdl == 8'h00)); end
      n_cmp++; if (zero !== (mdl == 8'h00)) begin n_err++; $display("FAIL rnd_zero cyc=%0d actual=%b required=%b", k, zero, (mdl == 8'h00)); end
      nd = clrn && !load && cnt_en && (mdl == 8'h01);
      if (!clrn) mdl = 8'h00;
      else if (load) mdl = ref_clamp(I);
      else if (cnt_en) mdl = ref_dec(mdl);
      mdone = nd;
      tick();
      n_cmp++; if (count !== mdl) begin n_err++; $display("FAIL rnd_count cyc=%0d actual=%h required=%h", k, count, mdl); end
      n_cmp++; if (count[7:4] > 4'd9 || count[3:0] > 4'd9) begin n_err++; $display("FAIL rnd_bcd cyc=%0d actual=%h required=bcd", k, count); end
      n_cmp++; if (done !== mdone) begin n_err++; $display("FAIL rnd_done cyc=%0d actual=%b required=%b", k, done, mdone); end
    end
    clrn = 1'b1; load = 1'b0; cnt_en = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_count_sequence();
    test_load_clamp();
    test_simultaneous();
    test_tens_borrow();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
